// File: rtl/dma_pkg.sv
// Shared types and constants for the word-copy DMA master: state encoding,
// address map limits and chip-select index construction.
package dma_pkg;
  localparam int ADDR_W    = 8;
  localparam int IDX_W     = 9;
  localparam int CS_BIT    = 8;
  localparam int MAX_ADDR  = 190;
  localparam int BOOK_ADDR = 191;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RD, S_CAPT, S_WR, S_NEXT, S_DONE, S_ERR
  } state_e;

  // Memory index with the chip select raised over a word address.
  function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_W-1:0] a);
    mem_idx             = '0;
    mem_idx[CS_BIT]     = 1'b1;
    mem_idx[ADDR_W-1:0] = a;
  endfunction
endpackage

// File: rtl/dma_mem_master_if.sv
// Request handshake and memory control signals of the DMA master.
// The shared databus stays a plain inout so tri-state resolution is flat.
interface dma_mem_master_if;
  import dma_pkg::*;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] count;
  logic              memfull;
  logic              busy;
  logic              done;
  logic              error;
  logic              memWR;
  logic [IDX_W-1:0]  index;

  modport master (input start, src_addr, dst_addr, count, memfull,
                  output busy, done, error, memWR, index);
  modport slave  (output start, src_addr, dst_addr, count, memfull,
                  input busy, done, error, memWR, index);
endinterface

// File: rtl/dma_addr_ctr.sv
// Loadable source/destination/remaining word counters; one step per copied word.
module dma_addr_ctr
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] cnt_i,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [ADDR_W-1:0] rem_o,
  output logic              zero_o
);
  logic [ADDR_W-1:0] src_q, dst_q, rem_q;
  logic [ADDR_W-1:0] src_d, dst_d, rem_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      rem_d = cnt_i;
    end else if (inc_i) begin
      src_d = src_q + 1'b1;
      dst_d = dst_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end

  assign src_o  = src_q;
  assign dst_o  = dst_q;
  assign rem_o  = rem_q;
  assign zero_o = (rem_q == '0);
endmodule

// File: rtl/dma_mem_master.sv
// Word-by-word memory copy master: range/full check, then read-hold, capture,
// two-cycle write and advance per word. All bus outputs are registered.
module dma_mem_master
  import dma_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_ADDR = dma_pkg::MAX_ADDR,
  parameter int RD_HOLD  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  dma_mem_master_if.master    bus,
  inout  wire  [DATA_W-1:0]   databus
);
  state_e            state_q;
  logic [DATA_W-1:0] hold_q;
  logic [2:0]        hcnt_q;
  logic              wr2_q;
  logic              busy_q, done_q, error_q, memwr_q;
  logic [IDX_W-1:0]  index_q;

  logic              ld, inc, zero, range_bad;
  logic [ADDR_W-1:0] cur_src, cur_dst, rem;
  logic [IDX_W-1:0]  src_end, dst_end;

  assign ld  = (state_q == S_IDLE) && bus.start;
  assign inc = (state_q == S_NEXT);

  dma_addr_ctr u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ld),
    .inc_i  (inc),
    .src_i  (bus.src_addr),
    .dst_i  (bus.dst_addr),
    .cnt_i  (bus.count),
    .src_o  (cur_src),
    .dst_o  (cur_dst),
    .rem_o  (rem),
    .zero_o (zero)
  );

  // 9-bit end addresses; only meaningful when rem != 0, which CHECK tests first.
  assign src_end   = {1'b0, cur_src} + {1'b0, rem} - 9'd1;
  assign dst_end   = {1'b0, cur_dst} + {1'b0, rem} - 9'd1;
  assign range_bad = (src_end > IDX_W'(MAX_ADDR)) || (dst_end > IDX_W'(MAX_ADDR));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      hcnt_q  <= '0;
      wr2_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      memwr_q <= 1'b0;
      index_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          state_q <= S_CHECK;
          busy_q  <= 1'b1;
        end
        S_CHECK:
          if (zero) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (range_bad || bus.memfull) begin
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            state_q <= S_RD;
            index_q <= mem_idx(cur_src);
            hcnt_q  <= '0;
          end
        S_RD:
          if (hcnt_q == 3'(RD_HOLD - 1)) state_q <= S_CAPT;
          else                           hcnt_q  <= hcnt_q + 1'b1;
        S_CAPT: begin
          hold_q  <= databus;
          state_q <= S_WR;
          index_q <= mem_idx(cur_dst);
          memwr_q <= 1'b1;
          wr2_q   <= 1'b0;
        end
        S_WR:
          if (wr2_q) begin
            state_q <= S_NEXT;
            index_q <= '0;
            memwr_q <= 1'b0;
          end else begin
            wr2_q <= 1'b1;
          end
        // Counters step on this edge, so the next read address is cur_src+1.
        S_NEXT:
          if (rem == 8'd1) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RD;
            index_q <= mem_idx(cur_src + 8'd1);
            hcnt_q  <= '0;
          end
        S_DONE, S_ERR: state_q <= S_IDLE;
        default:       state_q <= S_IDLE;
      endcase
    end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.error = error_q;
  assign bus.memWR = memwr_q;
  assign bus.index = index_q;

  assign databus = memwr_q ? hold_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_dma_mem_master.sv
// Bench for dma_mem_master: memory model on the shared bus, sequential-copy
// reference model, directed boundary cases and randomized transfers.
module tb_dma_mem_master;
  localparam int DW   = 32;
  localparam int MAXA = 190;
  localparam int H    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_mem_master_if bus();
  wire [DW-1:0] databus;

  logic [DW-1:0] mem      [0:255];
  logic [DW-1:0] ref_mem  [0:255];
  logic [DW-1:0] init_img [0:255];
  logic          init_go = 1'b0;

  int tests = 0;
  int fails = 0;

  dma_mem_master #(.DATA_W(DW), .MAX_ADDR(MAXA), .RD_HOLD(H)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .databus(databus));

  // Memory drives reads whenever selected and not in a write cycle.
  assign databus = (!bus.memWR && bus.index[8]) ? mem[bus.index[7:0]] : {DW{1'bz}};

  always @(posedge clk)
    if (init_go) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_img[a];
    end else if (bus.memWR && bus.index[8]) begin
      mem[bus.index[7:0]] <= databus;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus-protocol monitor: no master drive during reads, address map respected.
  always @(negedge clk)
    if (rst_n) begin
      if (!bus.memWR && bus.index[8]) begin
        tests++;
        assert (databus === mem[bus.index[7:0]]) else begin
          fails++;
          $error("FAIL mon_rdbus: observed %0h expected %0h", databus, mem[bus.index[7:0]]);
        end
      end
      if (bus.index[8]) begin
        tests++;
        assert (bus.index[7:0] <= 8'(MAXA)) else begin
          fails++;
          $error("FAIL mon_addr: observed %0d expected <= %0d", bus.index[7:0], MAXA);
        end
      end else begin
        tests++;
        assert ({bus.memWR, bus.index} === 10'd0) else begin
          fails++;
          $error("FAIL mon_idle: observed %0h expected 0", {bus.memWR, bus.index});
        end
      end
    end

  task automatic load_mem(input bit rnd);
    for (int a = 0; a < 256; a++) begin
      init_img[a] = rnd ? $urandom : 32'(a + 1);
      ref_mem[a]  = init_img[a];
    end
    @(negedge clk); init_go = 1'b1;
    @(posedge clk); #1 init_go = 1'b0;
  endtask

  task automatic cmp_mem(input string tag);
    int bad = 0;
    for (int a = 0; a <= MAXA + 1; a++) if (mem[a] !== ref_mem[a]) bad++;
    chk({tag, ":mem"}, 32'(bad), 0);
  endtask

  // One transfer against the reference: sequential ascending copy, 2-cycle reject.
  task automatic xfer(input int s, input int d, input int c, input bit mf, input string tag);
    int cyc;
    bit cs, exp_err, got_err;
    int exp_lat;
    if (c == 0) begin
      exp_err = 0; exp_lat = 2;
    end else if (s + c - 1 > MAXA || d + c - 1 > MAXA || mf) begin
      exp_err = 1; exp_lat = 2;
    end else begin
      exp_err = 0; exp_lat = 2 + c * (H + 4);
      for (int i = 0; i < c; i++) ref_mem[d + i] = ref_mem[s + i];
    end
    @(negedge clk);
    bus.src_addr = 8'(s); bus.dst_addr = 8'(d); bus.count = 8'(c);
    bus.memfull = mf; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; cs = 1'b0;
    chk({tag, ":busy"}, 32'(bus.busy), 1);
    while (!(bus.done || bus.error) && cyc < 3000) begin
      cs |= bus.index[8];
      if (cyc >= 2) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.memfull  = 1'($urandom_range(0, 1));
        bus.src_addr = 8'($urandom);
        bus.count    = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0; bus.memfull = 1'b0;
    got_err = bus.error;
    chk({tag, ":lat"},    32'(cyc), 32'(exp_lat));
    chk({tag, ":err"},    32'(got_err), 32'(exp_err));
    chk({tag, ":done"},   32'(bus.done), 32'(!exp_err));
    chk({tag, ":busy0"},  32'(bus.busy), 0);
    if (exp_err || c == 0) chk({tag, ":noacc"}, 32'(cs), 0);
    @(negedge clk);
    chk({tag, ":pulse"},  32'({bus.done, bus.error, bus.busy}), 0);
    cmp_mem(tag);
  endtask

  initial begin
    int n;
    logic [DW-1:0] old42;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
    bus.count = '0;   bus.memfull = 1'b0;
    #12;
    chk("rst:busy",  32'(bus.busy), 0);
    chk("rst:done",  32'(bus.done), 0);
    chk("rst:error", 32'(bus.error), 0);
    chk("rst:memWR", 32'(bus.memWR), 0);
    chk("rst:index", 32'(bus.index), 0);
    @(negedge clk); rst_n = 1'b1;

    load_mem(1'b0);
    xfer(0, 20, 5, 1'b0, "basic");
    for (int i = 0; i < 5; i++) chk("basic:word", mem[20 + i], 32'(i + 1));

    xfer(7, 9, 0, 1'b0, "cnt0");
    xfer(188, 10, 5, 1'b0, "srcrange");
    chk("srcrange:book", mem[191], 32'd192);
    xfer(10, 187, 5, 1'b0, "dstrange");
    xfer(0, 30, 3, 1'b1, "memfull");
    xfer(10, 12, 5, 1'b0, "overlap");
    xfer(186, 100, 5, 1'b0, "edge_src");
    xfer(50, 190, 1, 1'b0, "edge_dst");
    xfer(60, 55, 6, 1'b0, "down_ovl");

    load_mem(1'b1);
    for (int t = 0; t < 25; t++) begin
      int s, d, c;
      s = $urandom_range(0, MAXA);
      d = $urandom_range(0, MAXA);
      c = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 8);
      xfer(s, d, c, ($urandom_range(0, 7) == 0), "rand");
    end

    // Reset during the third word's write phase.
    load_mem(1'b1);
    old42 = ref_mem[42];
    @(negedge clk);
    bus.src_addr = 8'd0; bus.dst_addr = 8'd40; bus.count = 8'd5; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (!(bus.memWR && bus.index[7:0] == 8'd42) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("rst_mid:reach", 32'(n < 200), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid:memWR", 32'(bus.memWR), 0);
    chk("rst_mid:index", 32'(bus.index), 0);
    chk("rst_mid:busy",  32'(bus.busy), 0);
    repeat (3) @(negedge clk);
    chk("rst_mid:idle", 32'({bus.memWR, bus.index, bus.busy}), 0);
    chk("rst_mid:w0", mem[40], ref_mem[0]);
    chk("rst_mid:w1", mem[41], ref_mem[1]);
    chk("rst_mid:w2", 32'(mem[42] === ref_mem[2] || mem[42] === old42), 1);
    chk("rst_mid:w3", mem[43], ref_mem[43]);
    chk("rst_mid:w4", mem[44], ref_mem[44]);
    rst_n = 1'b1;

    load_mem(1'b1);
    xfer(3, 120, 7, 1'b0, "recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dma_mem_master.md
DMA_MEM_MASTER -- requirements
Module: dma_mem_master

Interface
REQ-001 Parameter DATA_W, default 32, shared data bus width.
REQ-002 Parameter MAX_ADDR, default 190, highest user word address; word 191 is memory bookkeeping, never accessed.
REQ-003 Parameter RD_HOLD, default 2, clocks the read address is held before data is captured (range 1..4).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle transfer request, sampled in IDLE only.
REQ-007 src_addr  input  8  first source word address.
REQ-008 dst_addr  input  8  first destination word address.
REQ-009 count  input  8  number of words to copy.
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse, transfer finished.
REQ-012 error  output  1  one-cycle pulse, request rejected.
REQ-013 memWR  output  1  1 = write cycle, 0 = read cycle.
REQ-014 index  output  9  bit 8 = memory chip select, bits 7:0 = word address.
REQ-015 databus  inout  DATA_W  shared bus; driven only while memWR=1, else high-Z.
REQ-016 memfull  input  1  memory full flag.

Function
REQ-017 Bus idle = index 9'h000, memWR 0, databus Z; held in IDLE, DONE, ERR.
REQ-018 States: IDLE, CHECK, RD, CAPT, WR, NEXT, DONE, ERR.
REQ-019 IDLE: start=1 -> latch src/dst/count into internal registers -> CHECK; start ignored in every other state.
REQ-020 CHECK, one cycle: count=0 -> DONE; src+count-1 > MAX_ADDR or dst+count-1 > MAX_ADDR (9-bit sums) -> ERR; memfull=1 -> ERR; else -> RD.
REQ-021 RD: index = {1, cur_src}, memWR 0, held RD_HOLD cycles.
REQ-022 CAPT, one cycle: databus sampled into a DATA_W holding register, index held.
REQ-023 WR: index = {1, cur_dst}, memWR 1, databus = holding register, held two cycles (memory samples on both edges).
REQ-024 NEXT, one cycle: bus idle, cur_src+1, cur_dst+1, remaining-1; remaining reaches 0 -> DONE, else -> RD.
REQ-025 Per-word latency = RD_HOLD + 1 + 2 + 1 cycles; total = 1 + count*(RD_HOLD+4) + 1 cycles from start to done.
REQ-026 Copy is strictly ascending, word by word; overlapping ranges with dst > src propagate copied words (defined behaviour, not corrected).
REQ-027 DONE and ERR last one cycle each, pulse done/error respectively, then -> IDLE.
REQ-028 memWR and databus drive change in the same edge; never drive databus while memWR=0 (no contention with the memory read driver).
REQ-029 memfull sampled only in CHECK; deassertion/assertion mid-transfer ignored.
REQ-030 Internal address arithmetic is 8-bit; the range check in REQ-020 guarantees no wrap.

Reset
REQ-031 rst_n low: immediately state IDLE, busy 0, done 0, error 0, memWR 0, index 0, databus Z, internal registers 0.
REQ-032 Reset mid-transfer abandons the copy; already-written destination words remain, no further bus activity.
REQ-033 First rising edge after rst_n release performs no action other than sampling start.

Structure
REQ-034 dma_pkg holds the state enum, MAX_ADDR, BOOK_ADDR=191 and CS bit position constants.
REQ-035 One sub-module, dma_addr_ctr: loadable src/dst/remaining counters with increment and zero flag.
REQ-036 Tri-state of databus is a single continuous assignment at the top level.

Verification
REQ-037 Memory words 0..4 = 1..5, start src=0 dst=20 count=5, RD_HOLD=2 -> words 20..24 = 1..5, done at cycle 32 after start.
REQ-038 count=0 -> done 2 cycles after start, index never has bit 8 set.
REQ-039 src=188 count=5 -> error pulse 2 cycles after start, no memory access, word 191 unchanged.
REQ-040 memfull=1 at start -> error pulse, no bus activity.
REQ-041 rst_n low during third word's WR phase of a count=5 copy -> bus idle within same cycle, only words 0..2 (or 0..1 plus partial) at destination, busy 0.
REQ-042 Throughout all tests: databus never driven by master while memWR=0 (X-check monitor).
